fnd_scan_controller: RTL

- Time-multiplexes a DIGITS-wide BCD word onto a shared 7-segment (FND) panel.
- Drives one BCD-to-font decoder, supplying its nibble and blank inputs, plus the active-low common (digit-select) lines.
- Buffers new display words in a shadow register and commits them only at frame boundaries, so a frame never shows mixed old and new digits.
- Adds optional leading-zero suppression and an anti-ghosting guard interval.

---
 rtl/fnd_scan_controller.sv | 93 +++++++++
 1 files changed

// File: rtl/fnd_scan_controller.sv
// Multiplexed 7-segment scan driver with a shadow-buffered display word,
// leading-zero suppression and an anti-ghosting guard interval.
module fnd_scan_controller #(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 100000,
   parameter int GUARD    = 0
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_enable,
   input  logic                  i_load,
   input  logic [4*DIGITS-1:0]   i_data,
   input  logic                  i_zero_blank,
   output logic [3:0]            o_value,
   output logic                  o_blank,
   output logic [DIGITS-1:0]     o_com,
   output logic                  o_pending,
   output logic                  o_frame
);
   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = $clog2(DIGITS);
   localparam int DW = 4 * DIGITS;

   logic [CW-1:0]     cnt;
   logic [IW-1:0]     idx;
   logic [DW-1:0]     disp;
   logic [DW-1:0]     pend_data;
   logic              tick;
   logic              frame_tick;
   logic              guard_ok;
   logic              visible;
   logic              suppressed;
   logic [DIGITS-1:0] lz;

   assign tick       = i_enable && (cnt == CW'(SCAN_DIV - 1));
   assign frame_tick = tick && (idx == IW'(DIGITS - 1));

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         cnt       <= '0;
         idx       <= '0;
         disp      <= '0;
         pend_data <= '0;
         o_pending <= 1'b0;
         o_frame   <= 1'b0;
      end else begin
         if (tick)
            cnt <= '0;
         else if (i_enable)
            cnt <= cnt + 1'b1;

         if (tick)
            idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;

         o_frame <= frame_tick;

         // A load landing on the commit edge goes straight to the display
         if (i_load && frame_tick) begin
            disp      <= i_data;
            pend_data <= i_data;
            o_pending <= 1'b0;
         end else if (i_load) begin
            pend_data <= i_data;
            o_pending <= 1'b1;
         end else if (frame_tick && o_pending) begin
            disp      <= pend_data;
            o_pending <= 1'b0;
         end
      end
   end

   generate
      if (GUARD == 0) begin : g_noguard
         assign guard_ok = 1'b1;
      end else begin : g_guard
         assign guard_ok = (cnt >= CW'(GUARD));
      end
   endgenerate

   // lz[i]: nibbles i..DIGITS-1 are all zero
   always_comb begin
      lz = '0;
      lz[DIGITS-1] = (disp[DW-1 -: 4] == 4'h0);
      for (int i = DIGITS - 2; i >= 0; i--)
         lz[i] = lz[i+1] && (disp[4*i +: 4] == 4'h0);
   end

   assign visible    = i_enable && guard_ok;
   assign suppressed = i_zero_blank && (idx != '0) && lz[idx];
   assign o_value    = disp[{idx, 2'b00} +: 4];
   assign o_blank    = !visible || suppressed;
   assign o_com      = visible ? ~(DIGITS'(1) << idx) : '1;
endmodule
